// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants.
//   - 4-bit opcode encodings (instr[3:0]); OP_SHIFT / OP_ORI decode on 3 bits.
//   - fetch_state_e: fetch-stage FSM states (RUN / SQUASH / HALT).
//   - is_stop(): helper recognising the stop opcode.
package cpu_pkg;

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STOP  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_NAND  = 4'h8;
  localparam logic [3:0] OP_NOP   = 4'hA;
  localparam logic [2:0] OP_SHIFT = 3'd3;
  localparam logic [2:0] OP_ORI   = 3'd7;

  typedef enum logic [1:0] {
    FS_RUN    = 2'd0,
    FS_SQUASH = 2'd1,
    FS_HALT   = 2'd2
  } fetch_state_e;

  function automatic logic is_stop(input logic [3:0] opcode);
    return opcode == OP_STOP;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry {instr, pc, valid} holding buffer for the fetch stage.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   push, in_instr, in_pc capture a word (push together with pop replaces the entry)
//   pop                   entry consumed this cycle
//   flush                 discard the entry (wins over push/pop)
//   out_instr/out_pc/out_valid  current entry
module fetch_skid #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               out_valid
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (push) begin
      valid_d = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign out_instr = instr_q;
  assign out_pc    = pc_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch feeding the read stage through IR1.
// Drives PC / instruction memory (1-cycle read latency), absorbs read-stage
// stalls in a 1-entry skid buffer, squashes on redirect, halts on the stop opcode.
// Ports:
//   clock, reset                  rising edge, synchronous active-high reset
//   stall                         read stage cannot take IR1 this cycle
//   redirect_valid, redirect_pc   branch-taken pulse and target
//   imem_rd, imem_addr, imem_rdata  instruction memory request / returned word
//   ir1, ir1_pc, ir1_valid        instruction presented to the read stage
//   en_read                       IR1 consumed this cycle
//   halted                        stop instruction held in IR1, fetch frozen
// Optional: FETCH_PERF_CNT_EN adds fetch_cnt (IR1 loads) and stall_cnt
// (stall & ir1_valid cycles), both 16-bit saturating.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_rd,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir1,
  output logic [ADDR_W-1:0]  ir1_pc,
  output logic               ir1_valid,
  output logic               en_read,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        fetch_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir1_q, ir1_d;
  logic [ADDR_W-1:0]  ir1_pc_q, ir1_pc_d;
  logic               ir1_valid_q, ir1_valid_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;

  logic               issue, load, ret_valid;
  logic [INSTR_W-1:0] load_instr;
  logic [ADDR_W-1:0]  load_pc;
  logic               skid_push, skid_pop, skid_flush, skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;

  assign en_read = ir1_valid_q & ~stall;

  fetch_skid #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (skid_push),
    .pop       (skid_pop),
    .flush     (skid_flush),
    .in_instr  (imem_rdata),
    .in_pc     (inflight_pc_q),
    .out_instr (skid_instr),
    .out_pc    (skid_pc),
    .out_valid (skid_valid)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir1_d         = ir1_q;
    ir1_pc_d      = ir1_pc_q;
    ir1_valid_d   = ir1_valid_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    issue         = 1'b0;
    load          = 1'b0;
    load_instr    = ir1_q;
    load_pc       = ir1_pc_q;
    skid_push     = 1'b0;
    skid_pop      = 1'b0;
    skid_flush    = 1'b0;
    // Returns are only honoured in RUN; SQUASH and HALT drop them.
    ret_valid     = inflight_q && (state_q == FS_RUN);

    case (state_q)
      FS_RUN: begin
        if (!ir1_valid_q || en_read) begin
          // Skid is older than any returning word, so it drains first.
          if (skid_valid) begin
            load       = 1'b1;
            load_instr = skid_instr;
            load_pc    = skid_pc;
            skid_pop   = 1'b1;
            skid_push  = ret_valid;
          end else if (ret_valid) begin
            load       = 1'b1;
            load_instr = imem_rdata;
            load_pc    = inflight_pc_q;
          end
          ir1_valid_d = load;
        end else begin
          skid_push = ret_valid;
        end
        if (load) begin
          ir1_d    = load_instr;
          ir1_pc_d = load_pc;
        end
        if (load && is_stop(load_instr[3:0])) begin
          state_d    = FS_HALT;
          skid_flush = 1'b1;
          inflight_d = 1'b0;
        end else begin
          issue      = !skid_valid && !(stall && ir1_valid_q && inflight_q);
          inflight_d = issue;
          if (issue) begin
            pc_d          = pc_q + 1'b1;
            inflight_pc_d = pc_q;
          end
        end
      end
      FS_SQUASH: begin
        issue         = 1'b1;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 1'b1;
        state_d       = FS_RUN;
      end
      FS_HALT: begin
        inflight_d = 1'b0;
      end
      default: begin
        state_d = FS_RUN;
      end
    endcase

    if (redirect_valid) begin
      state_d     = FS_SQUASH;
      pc_d        = redirect_pc;
      ir1_valid_d = 1'b0;
      issue       = 1'b0;
      load        = 1'b0;
      inflight_d  = 1'b0;
      skid_flush  = 1'b1;
      skid_push   = 1'b0;
      skid_pop    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= FS_RUN;
      pc_q          <= '0;
      ir1_q         <= '0;
      ir1_pc_q      <= '0;
      ir1_valid_q   <= 1'b0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir1_q         <= ir1_d;
      ir1_pc_q      <= ir1_pc_d;
      ir1_valid_q   <= ir1_valid_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign imem_rd   = issue & ~reset;
  assign imem_addr = pc_q;
  assign ir1       = ir1_q;
  assign ir1_pc    = ir1_pc_q;
  assign ir1_valid = ir1_valid_q;
  assign halted    = (state_q == FS_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (load && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (stall && ir1_valid_q && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a program-order model.
// The model tracks the next instruction the read stage must see and the next
// address that must be fetched; directed literals pin key cycles.
module tb_fetch_stage;

  logic       clock, reset, stall, redirect_valid;
  logic [7:0] redirect_pc;
  logic       imem_rd;
  logic [7:0] imem_addr, imem_rdata;
  logic [7:0] ir1, ir1_pc;
  logic       ir1_valid, en_read, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt, stall_cnt;
`endif

  logic [7:0] mem [256];
  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  // model state
  logic [7:0] exp_pc    = 8'h00;
  logic [7:0] fetch_ptr = 8'h00;
  bit         halted_m  = 1'b0;
  logic [7:0] stop_word = 8'h00;

  fetch_stage #(.ADDR_W(8), .INSTR_W(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_rd        (imem_rd),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .ir1            (ir1),
    .ir1_pc         (ir1_pc),
    .ir1_valid      (ir1_valid),
    .en_read        (en_read),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // synchronous memory: word appears the cycle after the request
  always @(posedge clock) begin
    if (imem_rd) imem_rdata <= mem[imem_addr];
    else         imem_rdata <= 8'hEE;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // program-order model, checked every cycle
  always @(negedge clock) begin
    if (armed) begin
      check("en_read_rule", en_read, ir1_valid & ~stall);
      if (reset || redirect_valid) check("no_fetch_on_rst_or_redirect", imem_rd, 1'b0);
      if (halted_m) begin
        check("halt_flag", halted, 1'b1);
        check("halt_ir1", ir1, stop_word);
        check("halt_ir1_valid", ir1_valid, 1'b1);
        check("halt_no_fetch", imem_rd, 1'b0);
      end else if (ir1_valid) begin
        check("order_ir1", ir1, mem[exp_pc]);
        check("order_ir1_pc", ir1_pc, exp_pc);
        check("halted_on_stop", halted, mem[exp_pc][3:0] == 4'h1);
        if (mem[exp_pc][3:0] == 4'h1) begin
          halted_m  = 1'b1;
          stop_word = mem[exp_pc];
        end else if (en_read) begin
          exp_pc = exp_pc + 8'd1;
        end
      end else begin
        check("halted_idle", halted, 1'b0);
      end
      if (imem_rd && !halted_m) begin
        check("fetch_addr_seq", imem_addr, fetch_ptr);
        fetch_ptr = fetch_ptr + 8'd1;
      end
      if (reset) begin
        exp_pc = 8'h00; fetch_ptr = 8'h00; halted_m = 1'b0;
      end else if (redirect_valid) begin
        exp_pc = redirect_pc; fetch_ptr = redirect_pc; halted_m = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  logic [39:0] stall_pat;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {i[3:0], 4'hA};
    mem[0] = 8'hA4; mem[1] = 8'h0A; mem[2] = 8'h34; mem[3] = 8'h18;
    mem[5] = 8'h01;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;

    tick(); armed = 1'b1; tick();
    check("rst_ir1_valid", ir1_valid, 1'b0);
    check("rst_ir1", ir1, 8'h00);
    check("rst_ir1_pc", ir1_pc, 8'h00);
    check("rst_halted", halted, 1'b0);
    check("rst_imem_rd", imem_rd, 1'b0);

    // 1: straight-line fetch
    reset = 1'b0; #1;
    check("first_rd", imem_rd, 1'b1);
    check("first_addr", imem_addr, 8'h00);
    tick();
    check("c1_addr", imem_addr, 8'h01);
    check("c1_ir1_valid", ir1_valid, 1'b0);
    tick();
    check("c2_ir1", ir1, 8'hA4);
    check("c2_ir1_pc", ir1_pc, 8'h00);
    check("c2_en_read", en_read, 1'b1);
    check("c2_addr", imem_addr, 8'h02);
`ifdef FETCH_PERF_CNT_EN
    check("c2_fetch_cnt", fetch_cnt, 16'd1);
`endif
    tick();
    check("c3_ir1", ir1, 8'h0A);
    check("c3_ir1_pc", ir1_pc, 8'h01);

    // 2: three-cycle stall, 34 captured in skid
    stall = 1'b1; #1;
    check("stall_rd0", imem_rd, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stall_ir1_hold", ir1, 8'h0A);
      check("stall_rd", imem_rd, 1'b0);
    end
    tick(); stall = 1'b0; #1;
    check("release_ir1", ir1, 8'h0A);
    check("release_en_read", en_read, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt3", stall_cnt, 16'd3);
`endif
    tick();
    check("after_stall_ir1", ir1, 8'h34);
    check("after_stall_pc", ir1_pc, 8'h02);
    tick(); tick();
    check("next_ir1", ir1, 8'h18);
    check("next_pc", ir1_pc, 8'h03);

    // 4: stop at address 5
    for (int k = 0; k < 10 && !halted; k++) tick();
    check("halt_reached", halted, 1'b1);
    check("halt_ir1_lit", ir1, 8'h01);
    check("halt_pc_lit", ir1_pc, 8'h05);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("halt_hold_rd", imem_rd, 1'b0);
      check("halt_hold_ir1", ir1, 8'h01);
    end
    redirect_valid = 1'b1; redirect_pc = 8'h10; #1;
    check("redir_rd", imem_rd, 1'b0);
    tick(); redirect_valid = 1'b0; #1;
    check("unhalt", halted, 1'b0);
    check("squash_valid", ir1_valid, 1'b0);
    check("squash_rd", imem_rd, 1'b1);
    check("squash_addr", imem_addr, 8'h10);
    tick(); tick();
    check("resume_pc", ir1_pc, 8'h10);
    check("resume_ir1", ir1, 8'h0A);

    // 3: redirect with stall asserted
    tick();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h40; #1;
    check("sr_rd", imem_rd, 1'b0);
    tick(); stall = 1'b0; redirect_valid = 1'b0; #1;
    check("sr_valid", ir1_valid, 1'b0);
    check("sr_rd1", imem_rd, 1'b1);
    check("sr_addr", imem_addr, 8'h40);
    tick(); tick();
    check("sr_ir1_pc", ir1_pc, 8'h40);
    check("sr_ir1", ir1, 8'h0A);

    // 5: PC wrap
    tick();
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    tick(); redirect_valid = 1'b0; #1;
    check("wrap_addr_fe", imem_addr, 8'hFE);
    tick();
    check("wrap_addr_ff", imem_addr, 8'hFF);
    tick();
    check("wrap_addr_00", imem_addr, 8'h00);
    check("wrap_pc_fe", ir1_pc, 8'hFE);
    check("wrap_ir1_fe", ir1, 8'hEA);
    tick();
    check("wrap_pc_ff", ir1_pc, 8'hFF);
    check("wrap_ir1_ff", ir1, 8'hFA);
    tick();
    check("wrap_pc_00", ir1_pc, 8'h00);
    check("wrap_ir1_00", ir1, 8'hA4);

    // 6: reset with skid full
    stall = 1'b1;
    tick();
    check("skid_full_hold", ir1, 8'hA4);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", ir1_valid, 1'b0);
    check("mid_rst_ir1", ir1, 8'h00);
    check("mid_rst_pc", ir1_pc, 8'h00);
    check("mid_rst_halted", halted, 1'b0);
    check("mid_rst_rd", imem_rd, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("mid_rst_fetch_cnt", fetch_cnt, 16'd0);
    check("mid_rst_stall_cnt", stall_cnt, 16'd0);
`endif
    reset = 1'b0; stall = 1'b0; #1;
    check("restart_rd", imem_rd, 1'b1);
    check("restart_addr", imem_addr, 8'h00);
    tick(); tick();
    check("restart_ir1", ir1, 8'hA4);
    check("restart_pc", ir1_pc, 8'h00);

    // mixed stall pattern, order checked by the model
    redirect_valid = 1'b1; redirect_pc = 8'h20;
    tick(); redirect_valid = 1'b0;
    stall_pat = 40'hF0_3C_A5_81_0E;
    for (int k = 0; k < 40; k++) begin
      stall = stall_pat[k];
      tick();
    end
    stall = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
